// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming SECDED sizing and bit-position helpers
package hamming_pkg;
  function automatic int calculate_m(input int k);
    int m;
    m = 1;
    for (int i = 0; i < 32; i++)
      if ((1 << m) < m + k + 1) m++;
    return m;
  endfunction
  function automatic bit is_pow2(input int x);
    return x != 0 && (x & (x - 1)) == 0;
  endfunction
  // position (1-based) of data bit j: the j-th non-power-of-two position
  function automatic int data_to_pos(input int j);
    int p;
    int n;
    p = 0;
    n = -1;
    for (int i = 1; i < 1024; i++)
      if (n < j && !is_pow2(i)) begin
        n++;
        p = i;
      end
    return p;
  endfunction
  // data bit index held at non-power-of-two position p
  function automatic int pos_to_data(input int p);
    int n;
    n = 0;
    for (int i = 1; i < 1024; i++)
      if (i < p && !is_pow2(i)) n++;
    return n;
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome and overall parity of a SECDED codeword
//   cw  : codeword, bit 0 = overall parity, bits N:1 = Hamming positions
//   syn : XOR of the indices of all set positions 1..N
//   pe  : XOR of all bits N:0 (1 = odd parity)
module hamming_syndrome #(
  parameter int N = 12,
  parameter int M = 4
) (
  input  logic [N:0]   cw,
  output logic [M-1:0] syn,
  output logic         pe
);
  always_comb begin
    syn = '0;
    for (int i = 1; i <= N; i++)
      if (cw[i]) syn = syn ^ M'(i);
    pe = ^cw;
  end
endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: 2-stage pipelined SECDED decoder with valid/ready handshake
//   clk_i, rst_i      : clock, synchronous active-high reset
//   cw_i, valid_i     : input codeword and its valid; ready_o accepts it
//   d_o, syn_o        : corrected data and syndrome of the delivered word
//   sec_o, ded_o      : single error corrected / double error detected
//   valid_o, ready_i  : output handshake
//   HAMMING_ERR_CNT_EN adds sec_cnt_o, ded_cnt_o, cnt_clr_i saturating error counters
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int K = 8,
  parameter int M = calculate_m(K),
  parameter int N = M + K,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N:0]       cw_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [K-1:0]     d_o,
  output logic [M-1:0]     syn_o,
  output logic             sec_o,
  output logic             ded_o,
  output logic             valid_o,
`ifdef HAMMING_ERR_CNT_EN
  output logic [CNT_W-1:0] sec_cnt_o,
  output logic [CNT_W-1:0] ded_cnt_o,
  input  logic             cnt_clr_i,
`endif
  input  logic             ready_i
);
  localparam logic [M-1:0] NL = M'(N);
  localparam logic [N:0] ONE = (N+1)'(1);
  logic s1_valid, s1_pe, pe, sec, ded, s2_adv;
  logic [N:0] s1_cw, fix;
  logic [M-1:0] s1_syn, syn;
  logic [K-1:0] d_fix;
  hamming_syndrome #(.N(N), .M(M)) u_syn (.cw(cw_i), .syn(syn), .pe(pe));
  assign s2_adv = !valid_o || ready_i;
  assign ready_o = !s1_valid || s2_adv;
  // syndrome 0 with odd parity means p0 itself flipped; nothing to fix in N:1
  assign sec = s1_pe && s1_syn <= NL;
  assign ded = s1_syn != '0 && (!s1_pe || s1_syn > NL);
  assign fix = s1_cw ^ (sec && s1_syn != '0 ? ONE << s1_syn : '0);
  always_comb begin
    d_fix = '0;
    for (int j = 0; j < K; j++) d_fix[j] = fix[data_to_pos(j)];
  end
  always_ff @(posedge clk_i)
    if (ready_o && valid_i) begin
      s1_cw <= cw_i;
      s1_syn <= syn;
      s1_pe <= pe;
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      s1_valid <= 1'b0;
      valid_o <= 1'b0;
      d_o <= '0;
      syn_o <= '0;
      sec_o <= 1'b0;
      ded_o <= 1'b0;
    end else begin
      if (ready_o) s1_valid <= valid_i;
      if (s2_adv) valid_o <= s1_valid;
      if (s2_adv && s1_valid) begin
        d_o <= d_fix;
        syn_o <= s1_syn;
        sec_o <= sec;
        ded_o <= ded;
      end
    end
`ifdef HAMMING_ERR_CNT_EN
  logic xfer;
  assign xfer = valid_o && ready_i;
  always_ff @(posedge clk_i) begin
    sec_cnt_o <= rst_i || cnt_clr_i ? '0 : xfer && sec_o && !(&sec_cnt_o) ? sec_cnt_o + 1'b1 : sec_cnt_o;
    ded_cnt_o <= rst_i || cnt_clr_i ? '0 : xfer && ded_o && !(&ded_cnt_o) ? ded_cnt_o + 1'b1 : ded_cnt_o;
  end
`endif
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder: directed self-checking bench for hamming_secded_decoder
module tb_hamming_secded_decoder;
  logic clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b1;
  logic [12:0] cw_i = '0;
  logic ready_o, sec_o, ded_o, valid_o;
  logic [7:0] d_o;
  logic [3:0] syn_o;
  int checks = 0, errors = 0;
  int sent, rcvd;
  logic stalled, seen;
`ifdef HAMMING_ERR_CNT_EN
  logic [1:0] sec_cnt_o, ded_cnt_o;
  logic cnt_clr_i = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  hamming_secded_decoder #(
`ifdef HAMMING_ERR_CNT_EN
    .CNT_W(2),
`endif
    .K(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cw_i(cw_i), .valid_i(valid_i), .ready_o(ready_o),
    .d_o(d_o), .syn_o(syn_o), .sec_o(sec_o), .ded_o(ded_o), .valid_o(valid_o),
`ifdef HAMMING_ERR_CNT_EN
    .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o), .cnt_clr_i(cnt_clr_i),
`endif
    .ready_i(ready_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one word through an idle pipeline with ready_i high; outputs checked 2 cycles after accept
  task automatic send_check(input string tag, input logic [12:0] cw, input logic [7:0] ed,
                            input logic [3:0] es, input logic esec, input logic eded);
    @(negedge clk_i);
    cw_i = cw;
    valid_i = 1'b1;
    ready_i = 1'b1;
    chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk({tag, "_early"}, 32'(valid_o), 32'd0);
    @(negedge clk_i);
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_d"}, 32'(d_o), 32'(ed));
    chk({tag, "_syn"}, 32'(syn_o), 32'(es));
    chk({tag, "_sec"}, 32'(sec_o), 32'(esec));
    chk({tag, "_ded"}, 32'(ded_o), 32'(eded));
  endtask
  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_d", 32'(d_o), 32'd0);
    chk("rst_syn", 32'(syn_o), 32'd0);
    chk("rst_flags", 32'({sec_o, ded_o}), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    send_check("clean05", 13'h05A, 8'h05, 4'd0, 1'b0, 1'b0);
    send_check("cleanFF", 13'h1EEE, 8'hFF, 4'd0, 1'b0, 1'b0);
    send_check("single6", 13'h01A, 8'h05, 4'd6, 1'b1, 1'b0);
    for (int p = 1; p <= 12; p++)
      send_check($sformatf("flip%0d", p), 13'h05A ^ (13'd1 << p), 8'h05, 4'(p), 1'b1, 1'b0);
    send_check("p0_05", 13'h05B, 8'h05, 4'd0, 1'b1, 1'b0);
    send_check("p0_FF", 13'h1EEF, 8'hFF, 4'd0, 1'b1, 1'b0);
    send_check("double", 13'h012, 8'h00, 4'd5, 1'b0, 1'b1);
    send_check("invalid13", 13'h148, 8'h05, 4'd13, 1'b0, 1'b1);
    // stream 6 single-error words (syndromes 1..6) with a 3-cycle sink stall
    sent = 0;
    rcvd = 0;
    stalled = 1'b0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      @(negedge clk_i);
      ready_i = !(c >= 3 && c < 6);
      valid_i = sent < 6;
      cw_i = 13'h05A ^ (13'd1 << (sent + 1));
      #1;
      if (valid_o && ready_i) begin
        chk("bp_order", 32'(syn_o), 32'(rcvd + 1));
        chk("bp_d", 32'(d_o), 32'h05);
        rcvd++;
      end
      if (valid_i && ready_o) sent++;
      if (!ready_o) stalled = 1'b1;
    end
    valid_i = 1'b0;
    chk("bp_count", 32'(rcvd), 32'd6);
    chk("bp_stall", 32'(stalled), 32'd1);
    // two words in flight, then reset
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    cw_i = 13'h05A;
    @(negedge clk_i);
    cw_i = 13'h1EEE;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("full_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    ready_i = 1'b1;
    chk("rst_flush", 32'(valid_o), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    chk("rst_no_deliver", 32'(seen), 32'd0);
`ifdef HAMMING_ERR_CNT_EN
    @(negedge clk_i);
    cnt_clr_i = 1'b1;
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    chk("cnt_cleared", 32'({sec_cnt_o, ded_cnt_o}), 32'd0);
    for (int i = 1; i <= 5; i++)
      send_check($sformatf("cnt%0d", i), 13'h05A ^ (13'd1 << i), 8'h05, 4'(i), 1'b1, 1'b0);
    @(negedge clk_i);
    chk("sec_sat", 32'(sec_cnt_o), 32'd3);
    chk("ded_zero", 32'(ded_cnt_o), 32'd0);
    send_check("clr_word", 13'h01A, 8'h05, 4'd6, 1'b1, 1'b0);
    cnt_clr_i = 1'b1;
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    chk("clr_priority", 32'(sec_cnt_o), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Downstream consumer of the combinational Hamming SECDED encoder. Takes the (N+1)-bit codeword (overall parity at bit 0, Hamming positions 1..N) and recovers the K data bits.
- Corrects any single-bit error and flags any double-bit error.
- Implemented as a 2-stage registered pipeline with valid/ready handshake on both sides, so it can sit between a channel/memory model and the data sink.

Parameters:
- K, 8, information bit count.
- M, calculate_m(K), parity bit count: smallest M with 2**M >= M+K+1 (4 for K=8).
- N, M+K, Hamming codeword length excluding overall parity (12 for K=8).
- CNT_W, 16, width of error counters (only used with the optional feature).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cw_i  in  N+1  codeword; bit 0 = overall parity p0, bits at powers of two = p1..pM, remaining positions = data ascending (d[0] at position 3).
- valid_i  in  1  cw_i valid.
- ready_o  out  1  decoder accepts cw_i this cycle.
- d_o  out  K  decoded/corrected data.
- syn_o  out  M  syndrome of the delivered word (positions M:1).
- sec_o  out  1  single error detected and corrected.
- ded_o  out  1  double (uncorrectable) error detected.
- valid_o  out  1  d_o/syn_o/sec_o/ded_o valid.
- ready_i  in  1  sink accepts output.

Behaviour:
- Reset: valid_o=0, d_o=0, syn_o=0, sec_o=0, ded_o=0, both stage valid bits cleared. ready_o=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight words.
- Handshake:
  - Input transfer when valid_i&&ready_o; output transfer when valid_o&&ready_i.
  - Output signals hold stable while valid_o&&!ready_i.
- Stage 1 (S1), on accept:
  - Register cw_i.
  - Register syndrome s = XOR of position indices i (1..N) with cw[i]=1.
  - Register overall parity pe = XOR of cw[N:0] (1 = odd = parity error).
- Stage 2 (S2) classification:
  - s==0, pe==0: no error. sec=0, ded=0.
  - s==0, pe==1: p0 itself flipped. sec=1; data unchanged.
  - s!=0, pe==1, s<=N: flip cw[s]. sec=1.
  - s!=0, pe==1, s>N: invalid position. ded=1; no correction.
  - s!=0, pe==0: ded=1; data extracted uncorrected.
  - sec_o and ded_o are never both 1.
- Latency: 2 cycles from input accept to valid_o with ready_i held high. Full throughput of 1 word/cycle.
- Stall: a stage advances when its successor is empty or advancing.
  - ready_o = !s1_valid || !valid_o || ready_i.
  - Simultaneous accept and deliver with a full pipeline is legal; no bubble.
- No combinational path from valid_i to valid_o. ready_o depends only on state and ready_i.

Optional Feature:
- Macro HAMMING_ERR_CNT_EN.
- Defined:
  - Adds ports sec_cnt_o and ded_cnt_o (out, CNT_W) and cnt_clr_i (in, 1).
  - Each counter increments by 1 on every output transfer whose sec_o (resp. ded_o) is 1.
  - Counters saturate at all-ones; no wrap.
  - cnt_clr_i (synchronous) zeroes both counters and takes priority over a simultaneous increment.
  - rst_i zeroes both counters.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package hamming_pkg:
  - calculate_m function.
  - is_pow2 function.
  - data_to_pos / pos_to_data mapping functions, shared with the encoder.
- Sub-module hamming_syndrome (combinational): cw in, syndrome and pe out. Instantiated in S1 and reusable by encoder checks.

Test Plan:
- Clean word: d=8'h05 encodes to cw=13'h05A -> after 2 cycles d_o=8'h05, syn_o=0, sec_o=0, ded_o=0.
- Single data error: cw=13'h01A (bit 6 flipped) -> d_o=8'h05, syn_o=6, sec_o=1, ded_o=0. Repeat with a flip at every position 1..12, each giving syn_o equal to the flipped position.
- Overall parity error: cw=13'h05B -> d_o=8'h05, syn_o=0, sec_o=1, ded_o=0.
- Double error: cw=13'h012 (bits 3 and 6 flipped) -> syn_o=5, sec_o=0, ded_o=1, d_o = raw extraction = 8'h00.
- Backpressure and reset:
  - Stream 6 words with ready_i low for 3 cycles mid-stream -> ready_o drops once both stages are full, no word lost/duplicated, order preserved.
  - Assert rst_i with 2 words in flight -> valid_o=0 the next cycle and neither word is delivered.
- With HAMMING_ERR_CNT_EN:
  - CNT_W=2, 5 single-error words -> sec_cnt_o saturates at 3.
  - cnt_clr_i pulsed together with an error transfer -> counter reads 0.
